// File: rtl/rwy_pkg.sv
// Shared constants and helpers for runway_allocator and its runway timers.
package rwy_pkg;

    localparam int PREF_LOW_BIT = 0;
    localparam int PASS_BIT     = 1;

    typedef enum logic [3:0] {
        SIG_IDLE = 4'b0000,
        SIG_RWY0 = 4'b1010,
        SIG_RWY1 = 4'b1011,
        SIG_DENY = 4'b1101
    } legacy_sig_e;

    // Runway index width, never below one bit.
    function automatic int rwy_idx_w(input int num_rwy);
        return (num_rwy > 1) ? $clog2(num_rwy) : 1;
    endfunction

endpackage

// File: rtl/runway_timer.sv
// Per-runway occupancy timer: a load marks the runway busy for exactly HOLD_CYCLES cycles.
module runway_timer #(
    parameter int HOLD_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_busy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(HOLD_CYCLES - 1);
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/runway_allocator.sv
// Queued runway allocator: FIFO of requests, preference-based runway pick, head timeout deny.
// Define RWY_LEGACY_SIGNAL_EN to add the 4-bit legacy_signal output (two-runway builds only).
module runway_allocator
    import rwy_pkg::*;
#(
    parameter int NUM_RWY     = 2,
    parameter int HOLD_CYCLES = 15,
    parameter int QDEPTH      = 4,
    parameter int MAX_WAIT    = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [1:0]                    req_type,
    output logic                          req_ready,
    output logic                          grant_valid,
    output logic                          grant_deny,
    output logic [rwy_idx_w(NUM_RWY)-1:0] grant_rwy,
    output logic [1:0]                    grant_type,
    output logic [NUM_RWY-1:0]            rwy_busy,
    output logic [$clog2(QDEPTH):0]       q_count
`ifdef RWY_LEGACY_SIGNAL_EN
    ,
    output logic [3:0]                    legacy_signal
`endif
);

    localparam int RW = rwy_idx_w(NUM_RWY);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [1:0]    r_q [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_fresh;
    logic [WW-1:0] r_wait;
    logic          r_gv;
    logic          r_gd;
    logic [RW-1:0] r_grwy;
    logic [1:0]    r_gtype;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_head_ok;
    logic               w_any_free;
    logic               w_timeout;
    logic [1:0]         w_head_type;
    logic [RW-1:0]      w_pick;
    logic [CW-1:0]      w_count_nxt;
    logic [NUM_RWY-1:0] w_busy;
    logic [NUM_RWY-1:0] w_load;

    assign w_ready     = (r_count != CW'(QDEPTH));
    assign w_push      = req_valid && w_ready;
    assign w_head_type = r_q[r_rd_ptr];
    // An entry written at the last edge into an empty queue is not dispatchable until the next cycle.
    assign w_head_ok   = (r_count != '0) && !r_fresh;
    assign w_any_free  = |(~w_busy);
    assign w_timeout   = (r_wait == WW'(MAX_WAIT));
    assign w_pop       = w_head_ok && (w_any_free || w_timeout);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_pick = '0;
        if (w_head_type[PREF_LOW_BIT]) begin
            for (int i = NUM_RWY - 1; i >= 0; i--) begin
                if (!w_busy[i]) w_pick = RW'(i);
            end
        end else begin
            for (int i = 0; i < NUM_RWY; i++) begin
                if (!w_busy[i]) w_pick = RW'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_RWY; g++) begin : g_rwy
        assign w_load[g] = w_pop && w_any_free && (w_pick == RW'(g));

        runway_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_timer (
            .clk   (clk),
            .rst   (rst),
            .i_load(w_load[g]),
            .o_busy(w_busy[g])
        );
    end

    // NOTE: queue storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wr_ptr] <= req_type;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fresh  <= 1'b0;
            r_wait   <= '0;
            r_gv     <= 1'b0;
            r_gd     <= 1'b0;
            r_grwy   <= '0;
            r_gtype  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_fresh <= w_push && (w_count_nxt == CW'(1));
            r_wait  <= (!w_head_ok || w_pop) ? '0 : r_wait + 1'b1;
            r_gv    <= w_pop;
            r_gd    <= w_pop && !w_any_free;
            if (w_pop) begin
                r_grwy  <= w_any_free ? w_pick : '0;
                r_gtype <= {w_head_type[PASS_BIT], w_head_type[PREF_LOW_BIT]};
            end
        end
    end

    assign req_ready   = w_ready;
    assign grant_valid = r_gv;
    assign grant_deny  = r_gd;
    assign grant_rwy   = r_grwy;
    assign grant_type  = r_gtype;
    assign rwy_busy    = w_busy;
    assign q_count     = r_count;

`ifdef RWY_LEGACY_SIGNAL_EN
    if (NUM_RWY != 2) begin : g_legacy_check
        $error("runway_allocator: legacy signal output requires NUM_RWY == 2");
    end

    logic [3:0] r_legacy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_legacy <= SIG_IDLE;
        end else if (w_pop) begin
            if (!w_any_free)        r_legacy <= SIG_DENY;
            else if (w_pick == '0)  r_legacy <= SIG_RWY0;
            else                    r_legacy <= SIG_RWY1;
        end
    end

    assign legacy_signal = r_legacy;
`endif

endmodule

// File: tb/tb_runway_allocator.sv
// Self-checking bench for runway_allocator: directed table, hand sequences, randomized model check.
module tb_runway_allocator;

    localparam int B_NR   = 2;
    localparam int B_HOLD = 20;
    localparam int B_QD   = 4;
    localparam int B_MW   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_vld = 1'b0;
    logic [1:0] a_type = 2'b00;
    logic       a_ready, a_gv, a_gd;
    logic [0:0] a_rwy;
    logic [1:0] a_gtype, a_busy;
    logic [2:0] a_qc;

    logic       b_vld = 1'b0;
    logic [1:0] b_type = 2'b00;
    logic       b_ready, b_gv, b_gd;
    logic [0:0] b_rwy;
    logic [1:0] b_gtype;
    logic [B_NR-1:0] b_busy;
    logic [2:0] b_qc;

`ifdef RWY_LEGACY_SIGNAL_EN
    logic [3:0] a_leg, b_leg;
`endif

    runway_allocator u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (a_vld),
        .req_type   (a_type),
        .req_ready  (a_ready),
        .grant_valid(a_gv),
        .grant_deny (a_gd),
        .grant_rwy  (a_rwy),
        .grant_type (a_gtype),
        .rwy_busy   (a_busy),
        .q_count    (a_qc)
`ifdef RWY_LEGACY_SIGNAL_EN
        ,
        .legacy_signal(a_leg)
`endif
    );

    runway_allocator #(
        .NUM_RWY    (B_NR),
        .HOLD_CYCLES(B_HOLD),
        .QDEPTH     (B_QD),
        .MAX_WAIT   (B_MW)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_vld),
        .req_type   (b_type),
        .req_ready  (b_ready),
        .grant_valid(b_gv),
        .grant_deny (b_gd),
        .grant_rwy  (b_rwy),
        .grant_type (b_gtype),
        .rwy_busy   (b_busy),
        .q_count    (b_qc)
`ifdef RWY_LEGACY_SIGNAL_EN
        ,
        .legacy_signal(b_leg)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       vld;
        logic [1:0] typ;
        logic       e_ready;
        logic       e_gv;
        logic       e_rwy;
        logic [1:0] e_gtype;
        logic [1:0] e_busy;
        logic [2:0] e_qc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic vld, input logic [1:0] typ, input logic rdy, input logic gv,
                       input logic rwy, input logic [1:0] gt, input logic [1:0] busy, input logic [2:0] qc);
        vec_t v;
        v.vld = vld; v.typ = typ; v.e_ready = rdy; v.e_gv = gv;
        v.e_rwy = rwy; v.e_gtype = gt; v.e_busy = busy; v.e_qc = qc;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic rdy, input logic [1:0] busy, input logic [2:0] qc);
        for (int i = 0; i < n; i++) add(1'b0, 2'b00, rdy, 1'b0, 1'b0, 2'b00, busy, qc);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic a_step(input logic vld, input logic [1:0] typ);
        a_vld = vld;
        a_type = typ;
        @(posedge clk);
        #1;
        a_vld = 1'b0;
    endtask

    task automatic b_step(input logic vld, input logic [1:0] typ);
        b_vld = vld;
        b_type = typ;
        @(posedge clk);
        #1;
        b_vld = 1'b0;
    endtask

    // Reference model for DUT B: queued requests with accept timestamps, runway free-at times.
    logic [1:0] m_qt[$];
    int         m_qa[$];
    int         m_free[B_NR];
    int         m_wait;
    int         m_now;

    initial begin
        // Reset state
        #2;
        check("reset_ready", 32'(a_ready), 1);
        check("reset_gv", 32'(a_gv), 0);
        check("reset_gd", 32'(a_gd), 0);
        check("reset_rwy", 32'(a_rwy), 0);
        check("reset_gtype", 32'(a_gtype), 0);
        check("reset_busy", 32'(a_busy), 0);
        check("reset_qc", 32'(a_qc), 0);

        // Directed table for the default configuration (HOLD 15, QDEPTH 4, 2 runways)
        add(1'b1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 3'd1);
        add(1'b0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 3'd1);
        add(1'b0, 2'b00, 1, 1, 1, 2'b00, 2'b10, 3'd0);
        idle(14, 1, 2'b10, 3'd0);
        idle(1, 1, 2'b00, 3'd0);
        add(1'b1, 2'b01, 1, 0, 0, 2'b00, 2'b00, 3'd1);
        add(1'b1, 2'b01, 1, 0, 0, 2'b00, 2'b00, 3'd2);
        add(1'b0, 2'b00, 1, 1, 0, 2'b01, 2'b01, 3'd1);
        add(1'b0, 2'b00, 1, 1, 1, 2'b01, 2'b11, 3'd0);
        add(1'b1, 2'b00, 1, 0, 0, 2'b00, 2'b11, 3'd1);
        add(1'b1, 2'b01, 1, 0, 0, 2'b00, 2'b11, 3'd2);
        add(1'b1, 2'b10, 1, 0, 0, 2'b00, 2'b11, 3'd3);
        add(1'b1, 2'b11, 0, 0, 0, 2'b00, 2'b11, 3'd4);
        add(1'b1, 2'b00, 0, 0, 0, 2'b00, 2'b11, 3'd4);
        idle(8, 0, 2'b11, 3'd4);
        idle(1, 0, 2'b10, 3'd4);
        add(1'b0, 2'b00, 1, 1, 0, 2'b00, 2'b01, 3'd3);
        add(1'b1, 2'b00, 1, 1, 1, 2'b01, 2'b11, 3'd3);
        idle(13, 1, 2'b11, 3'd3);
        idle(1, 1, 2'b10, 3'd3);
        add(1'b0, 2'b00, 1, 1, 0, 2'b10, 2'b01, 3'd2);
        add(1'b0, 2'b00, 1, 1, 1, 2'b11, 2'b11, 3'd1);
        idle(13, 1, 2'b11, 3'd1);
        idle(1, 1, 2'b10, 3'd1);
        add(1'b0, 2'b00, 1, 1, 0, 2'b00, 2'b01, 3'd0);
        idle(14, 1, 2'b01, 3'd0);
        idle(1, 1, 2'b00, 3'd0);

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            a_step(tbl[k].vld, tbl[k].typ);
            check($sformatf("tbl%0d_ready", k), 32'(a_ready), 32'(tbl[k].e_ready));
            check($sformatf("tbl%0d_gv", k), 32'(a_gv), 32'(tbl[k].e_gv));
            check($sformatf("tbl%0d_busy", k), 32'(a_busy), 32'(tbl[k].e_busy));
            check($sformatf("tbl%0d_qc", k), 32'(a_qc), 32'(tbl[k].e_qc));
            if (tbl[k].e_gv) begin
                check($sformatf("tbl%0d_gd", k), 32'(a_gd), 0);
                check($sformatf("tbl%0d_rwy", k), 32'(a_rwy), 32'(tbl[k].e_rwy));
                check($sformatf("tbl%0d_gtype", k), 32'(a_gtype), 32'(tbl[k].e_gtype));
            end
        end

        // Asynchronous reset right after a grant pulse, with requests still queued
        do_reset();
        a_step(1'b1, 2'b00);
        a_step(1'b1, 2'b00);
        a_step(1'b1, 2'b00);
        check("arst_pre_gv", 32'(a_gv), 1);
        check("arst_pre_qc", 32'(a_qc), 2);
        check("arst_pre_busy", 32'(a_busy), 32'(2'b10));
        #1 rst = 1'b1;
        #1;
        check("arst_gv", 32'(a_gv), 0);
        check("arst_busy", 32'(a_busy), 0);
        check("arst_qc", 32'(a_qc), 0);
        check("arst_ready", 32'(a_ready), 1);

`ifdef RWY_LEGACY_SIGNAL_EN
        do_reset();
        check("leg_reset", 32'(a_leg), 0);
        a_step(1'b1, 2'b00);
        a_step(1'b1, 2'b01);
        a_step(1'b0, 2'b00);
        check("leg_rwy1", 32'(a_leg), 32'(4'b1011));
        a_step(1'b0, 2'b00);
        check("leg_rwy0", 32'(a_leg), 32'(4'b1010));
        a_step(1'b0, 2'b00);
        check("leg_hold", 32'(a_leg), 32'(4'b1010));
`endif

        // Timeout deny on B: both runways held for 20 cycles, head waits 12 cycles
        do_reset();
        b_step(1'b1, 2'b01);
        b_step(1'b1, 2'b01);
        b_step(1'b1, 2'b00);
        check("deny_g1_gv", 32'(b_gv), 1);
        check("deny_g1_rwy", 32'(b_rwy), 0);
        b_step(1'b0, 2'b00);
        check("deny_g2_rwy", 32'(b_rwy), 1);
        check("deny_g2_busy", 32'(b_busy), 32'(2'b11));
        for (int i = 0; i < B_MW; i++) begin
            b_step(1'b0, 2'b00);
            check($sformatf("deny_early%0d", i), 32'(b_gv), 0);
        end
        check("deny_pre_qc", 32'(b_qc), 1);
        b_step(1'b0, 2'b00);
        check("deny_gv", 32'(b_gv), 1);
        check("deny_gd", 32'(b_gd), 1);
        check("deny_rwy", 32'(b_rwy), 0);
        check("deny_gtype", 32'(b_gtype), 0);
        check("deny_qc", 32'(b_qc), 0);
        check("deny_busy", 32'(b_busy), 32'(2'b11));
`ifdef RWY_LEGACY_SIGNAL_EN
        check("leg_deny", 32'(b_leg), 32'(4'b1101));
`endif

        // Deadline tie on B: runway 0 frees on the edge the wait count reaches MAX_WAIT
        do_reset();
        b_step(1'b1, 2'b01);
        b_step(1'b1, 2'b01);
        for (int i = 0; i < 7; i++) b_step(1'b0, 2'b00);
        check("tie_busy", 32'(b_busy), 32'(2'b11));
        b_step(1'b1, 2'b00);
        for (int i = 0; i < 13; i++) begin
            b_step(1'b0, 2'b00);
            check($sformatf("tie_wait%0d", i), 32'(b_gv), 0);
        end
        b_step(1'b0, 2'b00);
        check("tie_gv", 32'(b_gv), 1);
        check("tie_gd", 32'(b_gd), 0);
        check("tie_rwy", 32'(b_rwy), 0);
        check("tie_busy_after", 32'(b_busy), 32'(2'b01));

        // Randomized traffic on B against the reference model
        do_reset();
        m_qt.delete();
        m_qa.delete();
        for (int r = 0; r < B_NR; r++) m_free[r] = 0;
        m_wait = 0;
        m_now  = 0;
        for (int c = 0; c < 3000; c++) begin
            int pct;
            int pick;
            logic vld, head_ok, any_free, pop, push, e_gd;
            logic [1:0] typ, ht, e_gt;
            int e_rwy;
            logic [B_NR-1:0] e_busy;

            pct = ((c / 250) % 3 == 0) ? 20 : (((c / 250) % 3 == 1) ? 55 : 95);
            vld = ($urandom_range(99) < pct);
            typ = 2'($urandom_range(3));

            head_ok = (m_qt.size() > 0) && (m_qa[0] < m_now);
            ht = (m_qt.size() > 0) ? m_qt[0] : 2'b00;
            pick = -1;
            for (int r = 0; r < B_NR; r++) begin
                if (m_now >= m_free[r]) begin
                    if (ht[0]) begin
                        if (pick < 0) pick = r;
                    end else begin
                        pick = r;
                    end
                end
            end
            any_free = (pick >= 0);
            pop  = head_ok && (any_free || (m_wait == B_MW));
            push = vld && (m_qt.size() < B_QD);

            b_step(vld, typ);
            m_now++;

            e_gd = 1'b0; e_rwy = 0; e_gt = 2'b00;
            if (pop) begin
                e_gd  = !any_free;
                e_rwy = any_free ? pick : 0;
                e_gt  = m_qt.pop_front();
                void'(m_qa.pop_front());
                if (any_free) m_free[pick] = m_now + B_HOLD;
            end
            if (push) begin
                m_qt.push_back(typ);
                m_qa.push_back(m_now);
            end
            m_wait = (!head_ok || pop) ? 0 : m_wait + 1;
            for (int r = 0; r < B_NR; r++) e_busy[r] = (m_now < m_free[r]);

            check($sformatf("rnd%0d_gv", c), 32'(b_gv), 32'(pop));
            check($sformatf("rnd%0d_busy", c), 32'(b_busy), 32'(e_busy));
            check($sformatf("rnd%0d_qc", c), 32'(b_qc), 32'(m_qt.size()));
            check($sformatf("rnd%0d_ready", c), 32'(b_ready), 32'(m_qt.size() < B_QD));
            if (pop) begin
                check($sformatf("rnd%0d_gd", c), 32'(b_gd), 32'(e_gd));
                check($sformatf("rnd%0d_rwy", c), 32'(b_rwy), 32'(e_rwy));
                check($sformatf("rnd%0d_gtype", c), 32'(b_gtype), 32'(e_gt));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
